// File: rtl/mips_instr_encoder.sv
// Packs MIPS instruction requests into 32-bit words and streams them to an
// instruction memory. Optional delay-slot NOP padding: MIPS_ENC_DELAY_SLOT_PAD_EN.
module mips_instr_encoder #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_kind,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic [5:0]  req_funct,
  input  logic [15:0] req_imm,
  input  logic [25:0] req_target,
  input  logic        req_last,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  count,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  localparam logic [2:0] KIND_R    = 3'd0;
  localparam logic [2:0] KIND_LW   = 3'd1;
  localparam logic [2:0] KIND_SW   = 3'd2;
  localparam logic [2:0] KIND_BEQ  = 3'd3;
  localparam logic [2:0] KIND_BNE  = 3'd4;
  localparam logic [2:0] KIND_J    = 3'd5;
  localparam logic [2:0] KIND_ADDI = 3'd6;
  localparam logic [2:0] KIND_ANDI = 3'd7;

  localparam logic [8:0] DEPTH_W = 9'(DEPTH);

`ifdef MIPS_ENC_DELAY_SLOT_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  count_q, count_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic        pad_q, pad_d;
  logic        last_q, last_d;

  logic [31:0] enc_word;
  logic [5:0]  opcode;
  logic        is_branch;
  logic [8:0]  used_words;
  logic        ready;
  logic        accept;

  // Opcode and field packing for the requested kind.
  always_comb begin
    opcode    = 6'b000000;
    is_branch = 1'b0;
    case (req_kind)
      KIND_R:    opcode = 6'b000000;
      KIND_LW:   opcode = 6'b100011;
      KIND_SW:   opcode = 6'b101011;
      KIND_BEQ:  begin opcode = 6'b000100; is_branch = 1'b1; end
      KIND_BNE:  begin opcode = 6'b000101; is_branch = 1'b1; end
      KIND_J:    begin opcode = 6'b000010; is_branch = 1'b1; end
      KIND_ADDI: opcode = 6'b001000;
      KIND_ANDI: opcode = 6'b001100;
      default:   opcode = 6'b000000;
    endcase
  end

  always_comb begin
    enc_word = 32'h0;
    case (req_kind)
      KIND_R:  enc_word = {opcode, req_rs, req_rt, req_rd, 5'b00000, req_funct};
      KIND_J:  enc_word = {opcode, req_target};
      default: enc_word = {opcode, req_rs, req_rt, req_imm};
    endcase
  end

  // Words committed plus the one (or the pending NOP) still in flight.
  assign used_words = {1'b0, count_q} + {8'd0, we_q} + {8'd0, pad_q};

  // Handshake: a request transfers on a rising edge only when req_valid and
  // req_ready are both high; the encoded word is written in the next cycle.
  always_comb begin
    ready = 1'b0;
    if (state_q == S_RUN && !pad_q && used_words < DEPTH_W) begin
      if (PAD_EN && is_branch) ready = (used_words + 9'd2) <= DEPTH_W;
      else                     ready = 1'b1;
    end
  end

  assign accept = req_valid && ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    pad_d   = 1'b0;
    last_d  = last_q;

    // A write happening this cycle retires on the coming edge.
    if (we_q) begin
      addr_d  = addr_q + 32'd4;
      count_d = count_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          addr_d  = base_addr & 32'hFFFF_FFFC;
          count_d = 8'd0;
          last_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (pad_q) begin
          we_d    = 1'b1;
          wdata_d = 32'h0000_0000;
          if (last_q) state_d = S_DONE;
        end else if (accept) begin
          we_d    = 1'b1;
          wdata_d = enc_word;
          pad_d   = PAD_EN && is_branch;
          last_d  = req_last;
          if (req_last && !(PAD_EN && is_branch)) state_d = S_DONE;
        end else if (req_valid && used_words == DEPTH_W) begin
          state_d = S_ERROR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= 32'h0;
      count_q <= 8'd0;
      we_q    <= 1'b0;
      wdata_q <= 32'h0;
      pad_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      pad_q   <= pad_d;
      last_q  <= last_d;
    end
  end

  assign req_ready  = ready;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign busy       = (state_q == S_RUN) || (state_q == S_DONE);
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERROR);
  assign count      = count_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/mips_instr_encoder.md
MIPS_INSTR_ENCODER -- requirements
Module: mips_instr_encoder

Interface
REQ-001 SHALL have parameter: DEPTH, default 64, instruction-memory capacity in words (1..255).
REQ-002 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: start  in  1  begin a load session from base_addr.
REQ-005 SHALL have ports: base_addr  in  32  first byte address of the session.
REQ-006 SHALL have ports: req_valid  in  1 / req_ready  out  1  instruction-request handshake.
REQ-007 SHALL have ports: req_kind  in  3  0=R-format, 1=LW, 2=SW, 3=BEQ, 4=BNE, 5=J, 6=ADDI, 7=ANDI.
REQ-008 SHALL have ports: req_rs, req_rt, req_rd  in  5 each; req_funct  in  6; req_imm  in  16; req_target  in  26; req_last  in  1  final instruction of session.
REQ-009 SHALL have ports: imem_we  out  1; imem_addr  out  32; imem_wdata  out  32  instruction-memory write port.
REQ-010 SHALL have ports: busy  out  1; done  out  1; err  out  1; count  out  8  words written this session.

Function
REQ-011 SHALL have FSM states IDLE, RUN, DONE, ERROR.
REQ-012 IDLE: req_ready=0; start=1 -> RUN, addr register <= {base_addr[31:2],2'b00}, count <= 0.
REQ-013 RUN: req_ready=1 when count < DEPTH; busy=1; start ignored.
REQ-014 A transfer SHALL occur only on the clock edge where req_valid and req_ready are both 1.
REQ-015 Latency: an instruction accepted on edge N SHALL appear as imem_we=1, imem_wdata=encoded word, imem_addr=current addr during the cycle after edge N; addr += 4 and count += 1 on the following edge.
REQ-016 Throughput SHALL be one instruction per cycle; back-to-back writes SHALL use consecutive word addresses.
REQ-017 Encoding: R = {000000,rs,rt,rd,00000,funct}; LW = {100011,rs,rt,imm}; SW = {101011,rs,rt,imm}; BEQ = {000100,rs,rt,imm}; BNE = {000101,rs,rt,imm}; J = {000010,target}; ADDI = {001000,rs,rt,imm}; ANDI = {001100,rs,rt,imm}.
REQ-018 Fields not used by a kind SHALL be ignored (e.g. rd for LW, all register fields for J).
REQ-019 Accepting req_last=1 SHALL move RUN -> DONE; the final write SHALL occur in the DONE cycle.
REQ-020 DONE SHALL last exactly one cycle with done=1, then go to IDLE; count SHALL hold its final value until the next start.
REQ-021 req_valid=1 in RUN with count == DEPTH SHALL go to ERROR; ERROR: err=1, req_ready=0, no writes, exits only on rst.
REQ-022 addr SHALL wrap modulo 2^32 without error.
REQ-023 imem_we SHALL be 0 in every cycle not following an accepted transfer (or a pad, REQ-031).
REQ-024 busy SHALL be 1 in RUN and DONE, 0 in IDLE and ERROR.

Reset
REQ-025 rst=1 SHALL, on the next edge, force state=IDLE, req_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, count=0.
REQ-026 rst mid-session SHALL drop any accepted-but-unwritten instruction; no write SHALL occur in the cycle after the reset edge.
REQ-027 rst SHALL take priority over start, req_valid and all state transitions.

Configuration
REQ-028 Macro MIPS_ENC_DELAY_SLOT_PAD_EN SHALL select delay-slot padding.
REQ-029 With MIPS_ENC_DELAY_SLOT_PAD_EN defined, each accepted BEQ, BNE or J SHALL be followed by a write of 32'h00000000 (NOP) at the next word address in the next cycle.
REQ-030 The NOP write SHALL count toward count/DEPTH; req_ready=0 during that cycle.
REQ-031 If fewer than 2 words remain, a branch/jump SHALL NOT be accepted while padding is enabled (req_ready=0).
REQ-032 A branch/jump with req_last=1 SHALL signal done only after its NOP write.
REQ-033 Without MIPS_ENC_DELAY_SLOT_PAD_EN, no NOP SHALL be inserted and branch/jump SHALL behave like any other kind.

Verification
REQ-034 start, base_addr=0x00400000; R-format rs=1 rt=2 rd=3 funct=100000 -> cycle after accept: imem_we=1, addr 0x00400000, wdata 0x00221820.
REQ-035 Back-to-back LW rs=29 rt=8 imm=4 then ANDI rs=4 rt=5 imm=0x00FF (last) -> 0x8FA80004 @0x00400000, 0x308500FF @0x00400004, done pulse coincident with second write, count=2.
REQ-036 BEQ rs=1 rt=2 imm=0xFFFF then J target=0x0000010 -> 0x1022FFFF, 0x08000010; with pad macro: 0x1022FFFF, 0x00000000, 0x08000010, 0x00000000 at consecutive addresses.
REQ-037 DEPTH=4: four accepts, then req_valid=1 -> err=1, req_ready=0, no fifth write; rst clears err.
REQ-038 rst asserted the edge after an accept -> no imem_we in the following cycle; all outputs at reset values; a new start resumes normally.
REQ-039 base_addr=0x00000003 -> first write at 0x00000000; base_addr=0xFFFFFFFC with two writes -> second write at 0x00000000.
